// File: rtl/nn_seq_pkg.sv
// Shared types and constants for the NN layer sequencer and its optional
// performance counters.
package nn_seq_pkg;

    localparam int NUM_NEURONS = 4;
    localparam int MAX_LAYERS  = 8;
    localparam int BURST_LEN   = 4;
    localparam int CFG_FIELD_W = 3;
    localparam int WORD_W      = 16;

    // Q9.6 datapath word as seen by the MAC
    typedef logic [WORD_W-1:0] q9_6_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_RDY,
        ST_ISSUE,
        ST_DRAIN,
        ST_ACT,
        ST_FINISH
    } seq_state_t;

    // Index of the last input of a layer; a field of 0 means one input and
    // anything above the neuron count is capped there.
    function automatic logic [1:0] last_input_idx(input logic [CFG_FIELD_W-1:0] field);
        logic [1:0] idx;
        if (field == 3'd0) begin
            idx = 2'd0;
        end else if (field > 3'(NUM_NEURONS)) begin
            idx = 2'(NUM_NEURONS - 1);
        end else begin
            idx = 2'(field - 3'd1);
        end
        return idx;
    endfunction

endpackage

// File: rtl/nn_seq_perf_cnt.sv
// Saturating run-length and stall-cycle counters for the layer sequencer.
module nn_seq_perf_cnt (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        busy,
    input  logic        stall,
    output logic [15:0] cyc_count,
    output logic [15:0] stall_count
);

    // Both counters hold at all-ones instead of wrapping
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cyc_count   <= 16'd0;
            stall_count <= 16'd0;
        end else if (clear) begin
            cyc_count   <= 16'd0;
            stall_count <= 16'd0;
        end else begin
            if (busy && (cyc_count != 16'hFFFF)) begin
                cyc_count <= cyc_count + 16'd1;
            end
            if (stall && (stall_count != 16'hFFFF)) begin
                stall_count <= stall_count + 16'd1;
            end
        end
    end

endmodule

// File: rtl/nn_layer_sequencer.sv
// Walks the CORDIC NN through its layers in 4-word weight bursts and hands
// each finished layer to the activation unit. NN_SEQ_PERF_CNT_EN adds perf counters.
module nn_layer_sequencer
    import nn_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [3:0]  num_layers,
    input  logic [23:0] cfg_inputs,
    input  logic        mac_ready,
    input  logic        act_ack,
    output logic        weight_en,
    output logic        bias_en,
    output logic [5:0]  n,
    output logic [5:0]  i,
    output logic        mac_valid,
    output logic [1:0]  mac_k,
    output logic        mac_first,
    output logic        mac_last,
    output logic        act_req,
    output logic        busy,
    output logic        done
`ifdef NN_SEQ_PERF_CNT_EN
    ,
    output logic [15:0] cyc_count,
    output logic [15:0] stall_count
`endif
);

    seq_state_t  state_r, state_nxt_s;
    logic [2:0]  layer_r, layer_nxt_s;
    logic [1:0]  inp_r, inp_nxt_s;
    logic [1:0]  beat_r, beat_nxt_s;
    logic [3:0]  nl_r, nl_nxt_s;
    logic [23:0] cfg_r, cfg_nxt_s;
    logic [4:0]  fld_lsb_s;
    logic [1:0]  last_inp_s;
    logic        last_layer_s;
    logic        accept_s;

    // a start coinciding with the done pulse is dropped
    assign accept_s     = (state_r == ST_IDLE) && start && !done;
    assign fld_lsb_s    = 5'(layer_r) * 5'd3;
    assign last_inp_s   = last_input_idx(cfg_r[fld_lsb_s +: CFG_FIELD_W]);
    assign last_layer_s = ({1'b0, layer_r} == (nl_r - 4'd1));
    assign n            = {3'b000, layer_r};
    assign i            = {4'b0000, inp_r};

    // Next-state and counter update
    always_comb begin
        state_nxt_s = state_r;
        layer_nxt_s = layer_r;
        inp_nxt_s   = inp_r;
        beat_nxt_s  = beat_r;
        nl_nxt_s    = nl_r;
        cfg_nxt_s   = cfg_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    nl_nxt_s    = (num_layers > 4'(MAX_LAYERS)) ? 4'(MAX_LAYERS) : num_layers;
                    cfg_nxt_s   = cfg_inputs;
                    layer_nxt_s = 3'd0;
                    inp_nxt_s   = 2'd0;
                    beat_nxt_s  = 2'd0;
                    state_nxt_s = (num_layers == 4'd0) ? ST_FINISH : ST_WAIT_RDY;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT_RDY: begin
                if (mac_ready) begin
                    beat_nxt_s  = 2'd0;
                    state_nxt_s = ST_ISSUE;
                end else begin
                    state_nxt_s = ST_WAIT_RDY;
                end
            end
            ST_ISSUE: begin
                // the memory's k counter advances on its own, so a burst always runs to the end
                if (beat_r == 2'(BURST_LEN - 1)) begin
                    beat_nxt_s = 2'd0;
                    if (inp_r != last_inp_s) begin
                        inp_nxt_s   = inp_r + 2'd1;
                        state_nxt_s = mac_ready ? ST_ISSUE : ST_WAIT_RDY;
                    end else begin
                        state_nxt_s = ST_DRAIN;
                    end
                end else begin
                    beat_nxt_s = beat_r + 2'd1;
                end
            end
            ST_DRAIN: begin
                state_nxt_s = ST_ACT;
            end
            ST_ACT: begin
                if (act_ack) begin
                    if (last_layer_s) begin
                        state_nxt_s = ST_FINISH;
                    end else begin
                        layer_nxt_s = layer_r + 3'd1;
                        inp_nxt_s   = 2'd0;
                        state_nxt_s = ST_WAIT_RDY;
                    end
                end else begin
                    state_nxt_s = ST_ACT;
                end
            end
            ST_FINISH: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, counters and registered outputs; MAC tags trail weight_en by the memory latency
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            layer_r   <= 3'd0;
            inp_r     <= 2'd0;
            beat_r    <= 2'd0;
            nl_r      <= 4'd0;
            cfg_r     <= 24'd0;
            weight_en <= 1'b0;
            bias_en   <= 1'b0;
            mac_valid <= 1'b0;
            mac_k     <= 2'd0;
            mac_first <= 1'b0;
            mac_last  <= 1'b0;
            act_req   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            layer_r   <= layer_nxt_s;
            inp_r     <= inp_nxt_s;
            beat_r    <= beat_nxt_s;
            nl_r      <= nl_nxt_s;
            cfg_r     <= cfg_nxt_s;
            weight_en <= (state_nxt_s == ST_ISSUE);
            bias_en   <= (state_nxt_s == ST_ISSUE) && (inp_nxt_s == 2'd0);
            mac_valid <= weight_en;
            mac_k     <= weight_en ? beat_r : 2'd0;
            mac_first <= weight_en && (inp_r == 2'd0);
            mac_last  <= weight_en && (inp_r == last_inp_s);
            act_req   <= (state_nxt_s == ST_ACT);
            busy      <= (state_nxt_s != ST_IDLE);
            done      <= (state_r == ST_FINISH);
        end
    end

`ifdef NN_SEQ_PERF_CNT_EN
    nn_seq_perf_cnt u_perf_cnt (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (accept_s),
        .busy        (busy),
        .stall       ((state_r == ST_WAIT_RDY) || (state_r == ST_ACT)),
        .cyc_count   (cyc_count),
        .stall_count (stall_count)
    );
`endif

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Scoreboard bench for nn_layer_sequencer: memory accesses and MAC tags are
// predicted from the run configuration and matched as the DUT produces them.
module tb_nn_layer_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [3:0]  num_layers;
    logic [23:0] cfg_inputs;
    logic        mac_ready;
    logic        act_ack;
    logic        weight_en, bias_en, mac_valid, mac_first, mac_last, act_req, busy, done;
    logic [5:0]  n, i;
    logic [1:0]  mac_k;
`ifdef NN_SEQ_PERF_CNT_EN
    logic [15:0] cyc_count, stall_count;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int mv_cnt = 0;
    int busy_cnt = 0;
    int run_len = 0;
    bit mon_en = 1'b0;

    logic [12:0] acc_q[$];
    logic [3:0]  mac_q[$];

    always #5 clk = ~clk;

    nn_layer_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .num_layers (num_layers),
        .cfg_inputs (cfg_inputs),
        .mac_ready  (mac_ready),
        .act_ack    (act_ack),
        .weight_en  (weight_en),
        .bias_en    (bias_en),
        .n          (n),
        .i          (i),
        .mac_valid  (mac_valid),
        .mac_k      (mac_k),
        .mac_first  (mac_first),
        .mac_last   (mac_last),
        .act_req    (act_req),
        .busy       (busy),
        .done       (done)
`ifdef NN_SEQ_PERF_CNT_EN
        ,
        .cyc_count  (cyc_count),
        .stall_count(stall_count)
`endif
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Monitor: pops the scoreboards on every memory access and every MAC word
    always @(negedge clk) begin
        if (mon_en) begin
            if (busy) busy_cnt++;
            if (bias_en && !weight_en) check_val("bias_stray", 32'd1, 32'd0);
            if (weight_en) begin
                run_len++;
                if (acc_q.size() == 0) check_val("acc_extra", 32'd1, 32'd0);
                else check_val("acc_n_i_bias", 32'({n, i, bias_en}), 32'(acc_q.pop_front()));
            end else begin
                if (run_len != 0) check_val("burst_len_mod4", 32'(run_len % 4), 32'd0);
                run_len = 0;
            end
            if (mac_valid) begin
                mv_cnt++;
                if (mac_q.size() == 0) check_val("mac_extra", 32'd1, 32'd0);
                else check_val("mac_k_first_last", 32'({mac_k, mac_first, mac_last}), 32'(mac_q.pop_front()));
            end
        end else begin
            run_len = 0;
        end
    end

    task automatic run(input logic [3:0] nl, input logic [23:0] cfg, input int ack_delay,
                       input int stall_at, input int rst_at, input int exp_first_we, input int exp_done);
        int cyc = 0, we_seen = 0, first_we = -1, done_at = -1, done_cnt = 0;
        int act_cnt = 0, hold = 0, exp_words = 0, cnt;
        bit finished = 1'b0, resume_chk = 1'b0;
        logic [2:0] f;
        for (int l = 0; l < int'(nl); l++) begin
            f = cfg[l*3 +: 3];
            cnt = (f == 3'd0) ? 1 : ((f > 3'd4) ? 4 : int'(f));
            exp_words += cnt * 4;
            for (int ii = 0; ii < cnt; ii++) begin
                for (int k = 0; k < 4; k++) begin
                    acc_q.push_back({3'b000, 3'(l), 4'b0000, 2'(ii), (ii == 0)});
                    mac_q.push_back({2'(k), (ii == 0), (ii == cnt - 1)});
                end
            end
        end
        mv_cnt = 0;
        busy_cnt = 0;
        @(negedge clk);
        num_layers = nl;
        cfg_inputs = cfg;
        start = 1'b1;
        mon_en = 1'b1;
        while (!finished && cyc < 400) begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
            if (act_req) begin
                act_cnt++;
                act_ack = (act_cnt == ack_delay);
            end else begin
                act_cnt = 0;
                act_ack = 1'b0;
            end
            if (hold > 0) begin
                check_val("bp_we_low", 32'(weight_en), 32'd0);
                hold--;
                if (hold == 0) begin
                    mac_ready = 1'b1;
                    resume_chk = 1'b1;
                end
            end else if (resume_chk && weight_en) begin
                check_val("bp_resume_i", 32'(i), 32'd2);
                resume_chk = 1'b0;
            end
            if (weight_en) begin
                we_seen++;
                if (first_we < 0) first_we = cyc;
                if (stall_at > 0 && we_seen == stall_at) begin
                    mac_ready = 1'b0;
                    hold = 5;
                end
                if (rst_at > 0 && we_seen == rst_at) begin
                    mon_en = 1'b0;
                    rst_n = 1'b0;
                    @(negedge clk);
                    check_val("rst_mid_outputs", 32'({weight_en, bias_en, n, i, mac_valid, mac_k,
                              mac_first, mac_last, act_req, busy, done}), 32'd0);
                    rst_n = 1'b1;
                    act_ack = 1'b0;
                    mac_ready = 1'b1;
                    acc_q.delete();
                    mac_q.delete();
                    return;
                end
            end
            if (done) begin
                done_cnt++;
                if (done_at < 0) done_at = cyc;
            end
            if (done_at >= 0 && cyc >= done_at + 3) finished = 1'b1;
        end
        mon_en = 1'b0;
        if (!finished) check_val("run_timeout", 32'd0, 32'd1);
        check_val("done_once", 32'(done_cnt), 32'd1);
        check_val("acc_left", 32'(acc_q.size()), 32'd0);
        check_val("mac_left", 32'(mac_q.size()), 32'd0);
        check_val("mac_valid_count", 32'(mv_cnt), 32'(exp_words));
        check_val("busy_after", 32'(busy), 32'd0);
        if (exp_first_we >= 0) check_val("start_to_we", 32'(first_we), 32'(exp_first_we));
        if (exp_done >= 0) check_val("start_to_done", 32'(done_at), 32'(exp_done));
        acc_q.delete();
        mac_q.delete();
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        num_layers = 4'd0;
        cfg_inputs = 24'd0;
        mac_ready = 1'b1;
        act_ack = 1'b0;
        repeat (3) @(negedge clk);
        check_val("reset_outputs", 32'({weight_en, bias_en, n, i, mac_valid, mac_k,
                  mac_first, mac_last, act_req, busy, done}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // two layers with 4 and 2 inputs
        run(4'd2, 24'h000014, 1, 0, 0, 2, -1);
        // mac_ready dropped for 5 cycles after the second burst
        run(4'd2, 24'h000014, 1, 8, 0, -1, -1);
        // empty run
        run(4'd0, 24'h000000, 1, 0, 0, -1, 2);

        // start arriving together with done is ignored
        @(negedge clk);
        num_layers = 4'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check_val("nl0_done", 32'(done), 32'd1);
        num_layers = 4'd1;
        cfg_inputs = 24'h000001;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_val("start_during_done", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);

        // input fields 0 and 7 clamp to one and four bursts
        run(4'd2, 24'h000038, 1, 0, 0, 2, -1);
        // reset in the third cycle of the first burst, then a clean rerun
        run(4'd2, 24'h000014, 1, 0, 3, -1, -1);
        @(negedge clk);
        run(4'd2, 24'h000014, 1, 0, 0, 2, -1);

`ifdef NN_SEQ_PERF_CNT_EN
        run(4'd2, 24'h000014, 3, 0, 0, 2, -1);
        check_val("stall_count", 32'(stall_count), 32'd8);
        check_val("cyc_count", 32'(cyc_count), 32'(busy_cnt));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
